// File: rtl/z_result_seq.sv
// Result sequencer: captures the ALU's 2*REG_SIZE Z result and drains it as one (Z) or two (LO, HI) bus beats.
// Optional macro ZRESULT_FLAGS_EN enables the zero/negative condition flags; when undefined they read 0.
module z_result_seq #(
  parameter int REG_SIZE = 32
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [3:0]            alu_op,
  input  logic [2*REG_SIZE-1:0] z_data_in,
  input  logic                  cap_valid,
  output logic                  cap_ready,
  output logic [REG_SIZE-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            out_sel,
  output logic                  out_last,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic [1:0]            fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // The producer keeps valid and its payload stable until the transfer; the output
  // side never withdraws out_valid before out_ready is seen.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BEAT_LO = 2'd1,
    BEAT_HI = 2'd2
  } state_t;

  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [1:0] SEL_Z  = 2'b00;
  localparam logic [1:0] SEL_LO = 2'b01;
  localparam logic [1:0] SEL_HI = 2'b10;

  state_t              state;
  logic                mul;
  logic [REG_SIZE-1:0] held_hi;
  logic                is_mul;
  logic                capture;

  assign is_mul    = (alu_op == OP_MUL);
  assign capture   = cap_valid && cap_ready;
  assign fsm_state = state;

  // The low word of the held result lives in out_data from the capture edge
  // onward, so only the high word needs separate storage.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state     <= IDLE;
      mul       <= 1'b0;
      held_hi   <= '0;
      cap_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= SEL_Z;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            state     <= BEAT_LO;
            mul       <= is_mul;
            held_hi   <= z_data_in[2*REG_SIZE-1:REG_SIZE];
            cap_ready <= 1'b0;
            out_valid <= 1'b1;
            out_data  <= z_data_in[REG_SIZE-1:0];
            out_sel   <= is_mul ? SEL_LO : SEL_Z;
            out_last  <= !is_mul;
          end else begin
            cap_ready <= 1'b1;
          end
        end
        BEAT_LO: begin
          if (out_ready) begin
            if (mul) begin
              state    <= BEAT_HI;
              out_data <= held_hi;
              out_sel  <= SEL_HI;
              out_last <= 1'b1;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              cap_ready <= 1'b1;
            end
          end
        end
        BEAT_HI: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            cap_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          cap_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef ZRESULT_FLAGS_EN
  // Flags describe the whole product for mul, otherwise only the low word.
  always_ff @(posedge clock) begin
    if (!clear) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (capture) begin
      if (is_mul) begin
        flag_z <= (z_data_in == '0);
        flag_n <= z_data_in[2*REG_SIZE-1];
      end else begin
        flag_z <= (z_data_in[REG_SIZE-1:0] == '0);
        flag_n <= z_data_in[REG_SIZE-1];
      end
    end
  end
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
`endif

endmodule

// File: tb/tb_z_result_seq.sv
// Testbench for z_result_seq: directed steps then random traffic, checked against a beat-queue model.
module tb_z_result_seq;
  localparam int RS = 32;
  localparam int W  = 35;  // {sel[1:0], last, data[31:0]}

  logic          clock = 1'b0;
  logic          clear;
  logic [3:0]    alu_op;
  logic [2*RS-1:0] z_data_in;
  logic          cap_valid;
  logic          cap_ready;
  logic [RS-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_sel;
  logic          out_last;
  logic          flag_z;
  logic          flag_n;
  logic [1:0]    fsm_state;

  always #5 clock = ~clock;

  z_result_seq #(.REG_SIZE(RS)) dut (
    .clock     (clock),
    .clear     (clear),
    .alu_op    (alu_op),
    .z_data_in (z_data_in),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .fsm_state (fsm_state)
  );

  // Reference model: the result is a queue of pending beats; the block is
  // busy exactly while that queue is non-empty.
  logic [W-1:0] exp_q[$];
  logic exp_fz = 1'b0;
  logic exp_fn = 1'b0;
  logic released = 1'b0;
  logic in_reset = 1'b1;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic pre_valid;
    logic pre_ready;
    pre_valid = (exp_q.size() > 0);
    pre_ready = released && (exp_q.size() == 0);
    if (!clear) begin
      exp_q.delete();
      exp_fz   = 1'b0;
      exp_fn   = 1'b0;
      released = 1'b0;
      in_reset = 1'b1;
    end else begin
      in_reset = 1'b0;
      if (pre_valid && out_ready) begin
        void'(exp_q.pop_front());
      end else if (pre_ready && cap_valid) begin
        if (alu_op == 4'b1000) begin
          exp_q.push_back({2'b01, 1'b0, z_data_in[31:0]});
          exp_q.push_back({2'b10, 1'b1, z_data_in[63:32]});
          exp_fz = (z_data_in == 64'd0);
          exp_fn = z_data_in[63];
        end else begin
          exp_q.push_back({2'b00, 1'b1, z_data_in[31:0]});
          exp_fz = (z_data_in[31:0] == 32'd0);
          exp_fn = z_data_in[31];
        end
`ifndef ZRESULT_FLAGS_EN
        exp_fz = 1'b0;
        exp_fn = 1'b0;
`endif
      end
      released = 1'b1;
    end
  endtask

  task automatic step(input string tag);
    logic [W-1:0] b;
    @(posedge clock);
    model_edge();
    #1;
    check({tag, ".cap_ready"}, cap_ready, released && (exp_q.size() == 0));
    check({tag, ".out_valid"}, out_valid, exp_q.size() > 0);
    check({tag, ".flag_z"}, flag_z, exp_fz);
    check({tag, ".flag_n"}, flag_n, exp_fn);
    if (exp_q.size() > 0) begin
      b = exp_q[0];
      check({tag, ".out_data"}, out_data, b[31:0]);
      check({tag, ".out_sel"}, out_sel, b[34:33]);
      check({tag, ".out_last"}, out_last, b[32]);
    end else if (in_reset) begin
      check({tag, ".rst_data"}, out_data, 32'd0);
      check({tag, ".rst_sel"}, out_sel, 2'd0);
      check({tag, ".rst_last"}, out_last, 1'b0);
    end
  endtask

  initial begin
    // Reset held with cap_valid asserted: everything stays 0.
    clear     = 1'b0;
    cap_valid = 1'b1;
    alu_op    = 4'b1000;
    z_data_in = {$urandom, $urandom};
    out_ready = 1'b1;
    repeat (3) step("reset");
    clear     = 1'b1;
    cap_valid = 1'b0;
    step("release");

    // Single-beat add.
    alu_op    = 4'b0010;
    z_data_in = 64'h0000_0000_0000_0005;
    cap_valid = 1'b1;
    step("add_cap");
    cap_valid = 1'b0;
    step("add_done");

    // Two-beat mul, negative.
    alu_op    = 4'b1000;
    z_data_in = 64'hFFFF_FFFF_FFFF_FFFA;
    cap_valid = 1'b1;
    step("mul_cap");
    cap_valid = 1'b0;
    step("mul_hi");
    step("mul_done");

    // Backpressure on the LO beat with stray capture attempts.
    alu_op    = 4'b1000;
    z_data_in = {$urandom, $urandom};
    cap_valid = 1'b1;
    out_ready = 1'b0;
    step("bp_cap");
    for (int i = 0; i < 4; i++) begin
      cap_valid = 1'($urandom_range(0, 1));
      alu_op    = 4'($urandom_range(0, 15));
      z_data_in = {$urandom, $urandom};
      step("bp_hold");
    end
    cap_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step("bp_drain");

    // Reset while the HI beat is pending.
    alu_op    = 4'b1000;
    z_data_in = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
    cap_valid = 1'b1;
    out_ready = 1'b0;
    step("mid_cap");
    cap_valid = 1'b0;
    out_ready = 1'b1;
    step("mid_lo");
    clear = 1'b0;
    step("mid_rst");
    clear = 1'b1;
    repeat (3) step("mid_after");

    // Zero low word on a non-mul op.
    alu_op    = 4'b0000;
    z_data_in = 64'hDEAD_BEEF_0000_0000;
    cap_valid = 1'b1;
    step("zero_cap");
    cap_valid = 1'b0;
    step("zero_done");

    // Random traffic, including opcodes 1100-1111 and occasional resets.
    for (int i = 0; i < 400; i++) begin
      clear     = ($urandom_range(0, 39) != 0);
      cap_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      alu_op    = ($urandom_range(0, 2) == 0) ? 4'b1000 : 4'($urandom_range(0, 15));
      z_data_in = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) z_data_in[31:0] = 32'd0;
      if ($urandom_range(0, 7) == 0) z_data_in = 64'd0;
      step("rand");
    end
    clear     = 1'b1;
    cap_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
